// File: rtl/uart_tx_ser.sv
// Serial transmitter: accepts a parallel word on a valid/ready handshake and
// sends it as start bit, LSB-first data, optional even parity, then stop bit(s).
module uart_tx_ser #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  // Bit index also counts stop bits, so it needs at least one bit.
  localparam int unsigned IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;

  logic              bit_end_c;
  logic [DATA_W-1:0] shreg_next_c;

  // Bit-boundary detect and the next shift-register value.
  always_comb begin
    bit_end_c    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    shreg_next_c = shreg >> 1;
  end

  // Frame sequencer; tx, busy and tx_ready all come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      clk_cnt <= bit_end_c ? '0 : clk_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          clk_cnt  <= '0;
          bit_idx  <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            par_bit  <= ^tx_data;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
          end
        end
        START: begin
          if (bit_end_c) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end_c) begin
            shreg <= shreg_next_c;
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= shreg_next_c[0];
            end
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end_c) begin
            if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
              bit_idx  <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: three configurations checked against a frame model
// built from the line format (start, LSB-first data, even parity, stop bits).
module tb_uart_tx_ser;

  logic       clk;
  logic       reset;
  logic [2:0] valid;
  logic [7:0] data_a [3];
  wire  [2:0] ready;
  wire  [2:0] tx;
  wire  [2:0] busy;

  int n_checks;
  int n_pass;

  // Per-instance configuration: 0 defaults, 1 parity, 2 two stop bits fast.
  int cpb_t [3] = '{16, 16, 4};
  int par_t [3] = '{0, 1, 0};
  int sb_t  [3] = '{1, 1, 2};

  logic exp_q [$];
  time  acc_time;

  uart_tx_ser #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .STOP_BITS(1)) u_dflt (
    .clk(clk), .reset(reset), .tx_data(data_a[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx(tx[0]), .busy(busy[0]));

  uart_tx_ser #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .STOP_BITS(1)) u_par (
    .clk(clk), .reset(reset), .tx_data(data_a[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx(tx[1]), .busy(busy[1]));

  uart_tx_ser #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset(reset), .tx_data(data_a[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx(tx[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Expected per-cycle line level for one frame, starting the cycle after accept.
  task automatic build_exp(input int inst, input logic [7:0] d);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_t[inst] != 0) bits.push_back(logic'($countones(d) % 2));
    for (int i = 0; i < sb_t[inst]; i++) bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[b]) for (int c = 0; c < cpb_t[inst]; c++) exp_q.push_back(bits[b]);
  endtask

  task automatic wait_ready(input int inst);
    int k;
    k = 0;
    while (ready[inst] !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check("ready_timeout", 0, 1);
  endtask

  // Send one word and check every cycle of the frame plus the first idle cycle.
  task automatic send_frame(input int inst, input logic [7:0] d, input bit hold,
                            input bit change, input logic [7:0] d_new);
    wait_ready(inst);
    data_a[inst] = d;
    valid[inst]  = 1'b1;
    @(posedge clk);
    acc_time = $time;
    #1;
    if (!hold) valid[inst] = 1'b0;
    build_exp(inst, d);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (change && i == 50) data_a[inst] = d_new;
      check($sformatf("tx%0d_d%02h_c%0d", inst, d, i), tx[inst], exp_q[i]);
      check($sformatf("busy%0d_c%0d", inst, i), busy[inst], 1);
      check($sformatf("ready_low%0d_c%0d", inst, i), ready[inst], 0);
    end
    @(negedge clk);
    check($sformatf("ready_back%0d", inst), ready[inst], 1);
    check($sformatf("busy_clear%0d", inst), busy[inst], 0);
    check($sformatf("tx_idle%0d", inst), tx[inst], 1);
  endtask

  initial begin
    time  t_first;
    int   lows;
    n_checks = 0;
    n_pass   = 0;
    valid    = '0;
    for (int i = 0; i < 3; i++) data_a[i] = '0;

    // Reset then idle.
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", tx, 3'b111);
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", ready, 3'b111);
    check("tx_after_rst", tx, 3'b111);

    // Defaults: directed word then random words.
    send_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00);
    repeat (3) send_frame(0, 8'($urandom), 1'b0, 1'b0, 8'h00);

    // Parity configuration.
    send_frame(1, 8'h07, 1'b0, 1'b0, 8'h00);
    send_frame(1, 8'h03, 1'b0, 1'b0, 8'h00);
    repeat (3) send_frame(1, 8'($urandom), 1'b0, 1'b0, 8'h00);

    // Two stop bits at four clocks per bit.
    send_frame(2, 8'h00, 1'b0, 1'b0, 8'h00);
    repeat (3) send_frame(2, 8'($urandom), 1'b0, 1'b0, 8'h00);

    // Back-to-back with valid held and data changed mid-frame.
    send_frame(0, 8'h55, 1'b1, 1'b1, 8'h0F);
    t_first = acc_time;
    send_frame(0, 8'h0F, 1'b0, 1'b0, 8'h00);
    check("b2b_gap_cycles", int'((acc_time - t_first) / 10), 161);

    // Reset in the middle of data bit 3 of 8'hFF.
    wait_ready(0);
    data_a[0] = 8'hFF;
    valid[0]  = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    repeat (70) @(negedge clk);
    check("pre_abort_busy", busy[0], 1);
    #1;
    reset = 1'b0;
    #1;
    check("abort_tx_async", tx[0], 1);
    check("abort_busy", busy[0], 0);
    check("abort_ready", ready[0], 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready_back", ready[0], 1);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) lows++;
    end
    check("abort_no_residual", lows, 0);
    check("abort_idle_busy", busy[0], 0);

    // Random word after the abort still goes out correctly.
    send_frame(0, 8'($urandom), 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
